// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 1 start bit, LSB first, 1 stop bit.
// The line is resynchronised through two flops. A start bit is confirmed at
// half a bit time, and every later bit is sampled one bit time after that,
// which places each sample near mid-bit.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit between
// the data bits and the stop bit. Without the macro, o_parity_err is tied low.
module uart_rx #(
    parameter int unsigned CPB = 1250
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       i_Rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam int unsigned   CW       = $clog2(CPB);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Returns 1 when the received byte plus its parity bit has odd weight.
    function automatic logic parity_bad(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction
`endif

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          stop_tick_s;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    assign rx_s        = sync_q[1];
    assign stop_tick_s = (state_q == ST_STOP) && (cnt_q == CNT_BIT);

    // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_Rx};
        end
    end

    // FSM state register together with the bit counter, bit index and shift register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, mid-bit sampling and counter control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Output decode at the stop-bit sample: a framing error wins over a parity error, which wins over valid data.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (stop_tick_s) begin
            if (!rx_s) begin
                ferr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (parity_bad(shift_q, par_q)) begin
                perr_d = 1'b1;
            end
`endif
            else begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Registered outputs: the data byte is held between frames, and each status signal is a single-clock pulse.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CPB=16. A table of frames is driven one at a time,
// and the pulse counts and o_data are checked after each frame. Hand-written
// sequences cover glitches, a line held low, back-to-back frames and a reset
// in the middle of a frame.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 2 + CPB / 2 + 10 * CPB;
`else
    localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;
`endif

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_parity_err;

    uart_rx #(.CPB(CPB)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .i_Rx         (rx_line),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor. It samples on the falling edge and collects pulse counts and received bytes.
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_multi = 0, n_long = 0;
    int         valid_cyc = 0;
    int         rx_n = 0;
    logic [7:0] rx_log [0:63];
    logic       prev_any = 1'b0;
    always @(negedge clk) begin
        if (o_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
            if (rx_n < 64) rx_log[rx_n] <= o_data;
            rx_n <= rx_n + 1;
        end
        if (o_frame_err)  n_ferr <= n_ferr + 1;
        if (o_parity_err) n_perr <= n_perr + 1;
        if ((o_valid & o_frame_err) | (o_valid & o_parity_err) | (o_frame_err & o_parity_err))
            n_multi <= n_multi + 1;
        if (prev_any && (o_valid | o_frame_err | o_parity_err))
            n_long <= n_long + 1;
        prev_any <= o_valid | o_frame_err | o_parity_err;
    end

    int errors = 0;
    int checks = 0;
    int last_start = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Holds the line at v for one bit time. Every call starts and ends 1 time unit after a rising edge.
    task automatic bit_time(input logic v);
        rx_line = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
        last_start = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ bad_par);
`endif
        bit_time(stop);
    endtask

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       bad_par;
        int         exp_v;
        int         exp_fe;
        int         exp_pe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int bv, bf, bp, bn;
        logic [7:0] b7e;

        vecs.push_back('{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, 1, 0, 0, 8'h3C});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 0, 1, 0, 8'h3C});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1, 0, 0, 8'h81});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b0, 1, 0, 0, 8'h03});
        vecs.push_back('{8'h03, 1'b1, 1'b1, 0, 0, 1, 8'h03});
        vecs.push_back('{8'h96, 1'b0, 1'b1, 0, 1, 0, 8'h03});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  int'(o_data), 0);
        check("reset_valid", int'(o_valid), 0);
        check("reset_ferr",  int'(o_frame_err), 0);
        check("reset_perr",  int'(o_parity_err), 0);
        nRST = 1'b1;
        idle(2 * CPB);

        // Table-driven frames
        for (int i = 0; i < vecs.size(); i++) begin
            bv = n_valid; bf = n_ferr; bp = n_perr;
            send_frame(vecs[i].din, vecs[i].stop, vecs[i].bad_par);
            idle(2 * CPB);
            check($sformatf("vec%0d_valid", i), n_valid - bv, vecs[i].exp_v);
            check($sformatf("vec%0d_ferr", i),  n_ferr - bf,  vecs[i].exp_fe);
            check($sformatf("vec%0d_perr", i),  n_perr - bp,  vecs[i].exp_pe);
            check($sformatf("vec%0d_data", i),  int'(o_data), int'(vecs[i].exp_data));
            if (i == 0) begin
                checks++;
                if ((valid_cyc - last_start) < LAT_NOM - 1 || (valid_cyc - last_start) > LAT_NOM + 1) begin
                    errors++;
                    $display("FAIL latency: got %0d clocks, expected %0d +/-1", valid_cyc - last_start, LAT_NOM);
                end
            end
        end

        // A 3-clock glitch must not produce any pulse, and the next real frame must still be received
        bv = n_valid; bf = n_ferr; bp = n_perr;
        rx_line = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(3 * CPB);
        check("glitch_pulses", (n_valid - bv) + (n_ferr - bf) + (n_perr - bp), 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2 * CPB);
        check("after_glitch_valid", n_valid - bv, 1);
        check("after_glitch_data", int'(o_data), 8'h5A);

        // Frame error, then the line held low, then recovery
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(2 * CPB);
        bv = n_valid; bf = n_ferr;
        send_frame(8'hC3, 1'b0, 1'b0);
        rx_line = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("hold_low_ferr", n_ferr - bf, 1);
        check("hold_low_valid", n_valid - bv, 0);
        check("hold_low_data", int'(o_data), 8'h3C);
        idle(2 * CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2 * CPB);
        check("recover_valid", n_valid - bv, 1);
        check("recover_data", int'(o_data), 8'h81);

        // Back-to-back frames with no idle gap between them
        bn = rx_n;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2 * CPB);
        check("b2b_count", rx_n - bn, 3);
        check("b2b_0", int'(rx_log[bn]), 8'h00);
        check("b2b_1", int'(rx_log[bn + 1]), 8'hFF);
        check("b2b_2", int'(rx_log[bn + 2]), 8'h55);

        // Reset asserted during bit 4 of a 0x7E frame
        bv = n_valid; bf = n_ferr; bp = n_perr;
        b7e = 8'h7E;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(b7e[i]);
        rx_line = b7e[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        nRST = 1'b0;
        #2;
        check("midrst_data", int'(o_data), 0);
        check("midrst_valid", int'(o_valid), 0);
        repeat (4) @(posedge clk);
        #1;
        rx_line = 1'b1;
        nRST = 1'b1;
        idle(12 * CPB);
        check("midrst_no_pulse", (n_valid - bv) + (n_ferr - bf) + (n_perr - bp), 0);
        check("midrst_data_held", int'(o_data), 0);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(2 * CPB);
        check("after_rst_valid", n_valid - bv, 1);
        check("after_rst_data", int'(o_data), 8'h12);

        // Pulse rules over the whole run: no two status pulses in one clock, and every pulse lasts one clock
        check("never_two_pulses", n_multi, 0);
        check("one_clock_pulses", n_long, 0);
`ifndef UART_RX_PARITY_EN
        check("parity_err_tied", n_perr, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
